// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle LEGv8 control sequencer.
// Steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB. It owns the
// instruction register and the imem/dmem request/ack handshakes, and a
// watchdog bounds every memory wait.
// Optional feature: define SEQ_SINGLE_STEP_EN to add a `step` input. With it,
// the sequencer parks in STALL after each WB until `step` is seen.
module cpu_sequencer #(
  parameter int WD_LIMIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             zero,
  output logic [31:0]      ir,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             reg2loc,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_en,
  output logic             br_taken,
  output logic             uncond_br,
  output logic             halted,
  output logic             wd_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b000;
  // The watchdog fires on the no-ack cycle that would bring the count to WD_LIMIT
  localparam logic [7:0] WD_LAST = 8'(WD_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
`ifdef SEQ_SINGLE_STEP_EN
    , STALL
`endif
  } state_t;

  state_t     state, state_n;
  logic [7:0] wd_cnt;
  logic       wd_fire;
  logic       i_ack, d_ack;
  logic       zflag;
  logic       is_b, is_cbz, is_ldur, is_stur, is_hlt, is_wr;

  // Instruction class decode straight off the instruction register
  logic d_b, d_cbz, d_ldur, d_stur, d_adds, d_subs, d_addi, d_hlt;
  assign d_hlt  = (ir == 32'hD440_0000);
  assign d_b    = (ir[31:26] == 6'b000101);
  assign d_cbz  = (ir[31:24] == 8'b10110100);
  assign d_ldur = (ir[31:21] == 11'b11111000010);
  assign d_stur = (ir[31:21] == 11'b11111000000);
  assign d_adds = (ir[31:21] == 11'b10101011000);
  assign d_subs = (ir[31:21] == 11'b11101011000);
  assign d_addi = (ir[31:22] == 10'b1001000100);

  // An ack only counts while its own request is up
  assign i_ack = imem_req & imem_ack;
  assign d_ack = dmem_req & dmem_ack;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; an ack takes priority over a watchdog expiry in the same cycle
  always_comb begin
    state_n = state;
    wd_fire = 1'b0;
    case (state)
      IDLE:   state_n = FETCH;
      FETCH: begin
        if (i_ack) state_n = DECODE;
        else if (wd_cnt == WD_LAST) begin
          state_n = HALT;
          wd_fire = 1'b1;
        end
      end
      DECODE: state_n = EXEC;
      EXEC:   state_n = (is_ldur | is_stur) ? MEM : WB;
      MEM: begin
        if (d_ack) state_n = WB;
        else if (wd_cnt == WD_LAST) begin
          state_n = HALT;
          wd_fire = 1'b1;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      WB:     state_n = is_hlt ? HALT : STALL;
      STALL:  if (step) state_n = FETCH;
`else
      WB:     state_n = is_hlt ? HALT : FETCH;
`endif
      HALT:   state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // Registered requests follow the next state, so they drop the cycle after the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end else begin
      imem_req <= (state_n == FETCH);
      dmem_req <= (state_n == MEM);
      dmem_we  <= (state_n == MEM) & is_stur;
    end
  end

  // Watchdog: cleared on entry to a wait state, counts unanswered request cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_cnt <= '0;
    else if ((state_n == FETCH && state != FETCH) || (state_n == MEM && state != MEM))
      wd_cnt <= '0;
    else if ((imem_req & ~imem_ack) | (dmem_req & ~dmem_ack))
      wd_cnt <= wd_cnt + 8'd1;
  end

  // Sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
      wd_err <= 1'b0;
    end else begin
      halted <= halted | (state_n == HALT);
      wd_err <= wd_err | wd_fire;
    end
  end

  // Instruction register loads on the honoured fetch ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       ir <= '0;
    else if (state == FETCH && i_ack) ir <= instr;
  end

  // Datapath controls and class flags latched at DECODE, held until the next DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op     <= OP_PASS;
      alu_src    <= 1'b0;
      reg2loc    <= 1'b0;
      mem_to_reg <= 1'b0;
      is_b       <= 1'b0;
      is_cbz     <= 1'b0;
      is_ldur    <= 1'b0;
      is_stur    <= 1'b0;
      is_hlt     <= 1'b0;
      is_wr      <= 1'b0;
    end else if (state == DECODE) begin
      alu_op     <= (d_adds | d_addi | d_ldur | d_stur) ? OP_ADD :
                    d_subs ? OP_SUB : OP_PASS;
      alu_src    <= d_addi | d_ldur | d_stur;
      reg2loc    <= d_adds | d_subs;
      mem_to_reg <= d_ldur;
      is_b       <= d_b;
      is_cbz     <= d_cbz;
      is_ldur    <= d_ldur;
      is_stur    <= d_stur;
      is_hlt     <= d_hlt;
      is_wr      <= d_adds | d_subs | d_addi | d_ldur;
    end
  end

  // Zero flag captured at the end of EXEC for CBZ
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              zflag <= 1'b0;
    else if (state == EXEC) zflag <= zero;
  end

  // Retired-instruction counter, bumps once per WB (HLT included)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            retired <= '0;
    else if (state == WB) retired <= retired + CNT_W'(1);
  end

  // Single-cycle WB strobes
  assign pc_en     = (state == WB) & ~is_hlt;
  assign reg_write = (state == WB) & is_wr;
  assign br_taken  = (state == WB) & (is_b | (is_cbz & zflag));
  assign uncond_br = (state == WB) & is_b;

endmodule
